// File: rtl/fetch_ctrl.sv
// Fetch-side controller: next-PC selection, PC write-enable, IF/ID register,
// fetch-fault halt FSM and accepted-instruction counter (delay-slot semantics).
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic        stall,
  input  logic        id_branch,
  input  logic [31:0] id_branch_target,
  input  logic        id_jump,
  input  logic [25:0] id_jump_index,
  input  logic        id_jr,
  input  logic [31:0] id_jr_target,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_next;
  logic        fault;
  logic [32:0] im_end;
  logic [31:0] pc_plus4_f;
  logic [31:0] pc_plus4_d;

  // 33-bit bounds so an IM region ending at 2^32 does not wrap
  always_comb begin
    im_end     = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);
    fault      = (pc_f[1:0] != 2'b00)
              || ({1'b0, pc_f} < {1'b0, IM_BASE})
              || ({1'b0, pc_f} >= im_end);
    pc_plus4_f = pc_f + 32'd4;
    pc_plus4_d = pc_d + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == RUN && !stall && fault) state_next = HALT;
  end

  always_comb begin
    pc_en     = !reset && (state == RUN) && !stall && !fault;
    fetch_err = (state == HALT);
    pc_next   = pc_plus4_f;
    if (pc_en) begin
      if (id_jr)          pc_next = id_jr_target;
      else if (id_jump)   pc_next = {pc_plus4_d[31:28], id_jump_index, 2'b00};
      else if (id_branch) pc_next = id_branch_target;
    end
  end

  // No flush on redirect: the delay-slot instruction already in IF is kept
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_d   <= '0;
      pc_d      <= RESET_PC;
      pc8_d     <= RESET_PC + 32'd8;
      valid_d   <= 1'b0;
      fetch_cnt <= '0;
    end else if (state == RUN && !stall) begin
      pc_d  <= pc_f;
      pc8_d <= pc_f + 32'd8;
      if (fault) begin
        instr_d <= '0;
        valid_d <= 1'b0;
      end else begin
        instr_d   <= instr_f;
        valid_d   <= 1'b1;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a driver pushes model expectations per cycle,
// a monitor pops them and compares the combinational and registered outputs.
module tb_fetch_ctrl;

  localparam longint unsigned BASE  = 64'h3000;
  localparam longint unsigned WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_f = 32'h3000;
  logic [31:0] instr_f = '0;
  logic        stall = 1'b0;
  logic        id_branch = 1'b0;
  logic [31:0] id_branch_target = '0;
  logic        id_jump = 1'b0;
  logic [25:0] id_jump_index = '0;
  logic        id_jr = 1'b0;
  logic [31:0] id_jr_target = '0;
  logic [31:0] pc_next, instr_d, pc_d, pc8_d, fetch_cnt;
  logic        pc_en, valid_d, fetch_err;

  fetch_ctrl #(.RESET_PC(32'h3000), .IM_BASE(32'h3000), .IM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .pc_f(pc_f), .instr_f(instr_f), .stall(stall),
    .id_branch(id_branch), .id_branch_target(id_branch_target),
    .id_jump(id_jump), .id_jump_index(id_jump_index),
    .id_jr(id_jr), .id_jr_target(id_jr_target),
    .pc_next(pc_next), .pc_en(pc_en), .instr_d(instr_d), .pc_d(pc_d),
    .pc8_d(pc8_d), .valid_d(valid_d), .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] next;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: what the IF/ID stage should hold
  logic        m_halt = 1'b0;
  logic [31:0] m_instr = '0, m_pc = 32'h3000, m_pc8 = 32'h3008, m_cnt = '0;
  logic        m_valid = 1'b0;
  logic        last_en = 1'b0;
  logic [31:0] last_next = '0;

  function automatic logic is_fault(input logic [31:0] a);
    longint unsigned v = 64'(a);
    return (a[1:0] != 2'b00) || (v < BASE) || (v >= BASE + 4 * WORDS);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                       input logic st, input logic br, input logic [31:0] bt,
                       input logic j, input logic [25:0] idx,
                       input logic jrr, input logic [31:0] jrt);
    exp_t e;
    logic flt;
    logic [31:0] seq, link;
    @(negedge clk);
    reset = r; pc_f = pc; instr_f = ins; stall = st;
    id_branch = br; id_branch_target = bt; id_jump = j; id_jump_index = idx;
    id_jr = jrr; id_jr_target = jrt;
    #1;
    flt  = is_fault(pc);
    seq  = pc + 32'd4;
    link = m_pc + 32'd4;
    e.en = !r && !m_halt && !st && !flt;
    if (!e.en)    e.next = seq;
    else if (jrr) e.next = jrt;
    else if (j)   e.next = {link[31:28], idx, 2'b00};
    else if (br)  e.next = bt;
    else          e.next = seq;
    if (r) begin
      m_halt = 0; m_instr = 0; m_pc = 32'h3000; m_pc8 = 32'h3008; m_valid = 0; m_cnt = 0;
    end else if (!m_halt && !st) begin
      m_pc = pc; m_pc8 = pc + 32'd8;
      if (flt) begin
        m_instr = 0; m_valid = 0; m_halt = 1;
      end else begin
        m_instr = ins; m_valid = 1; m_cnt = m_cnt + 32'd1;
      end
    end
    e.instr = m_instr; e.pc = m_pc; e.pc8 = m_pc8; e.valid = m_valid;
    e.err = m_halt; e.cnt = m_cnt;
    last_en = e.en; last_next = e.next;
    q.push_back(e);
  endtask

  task automatic run(input logic [31:0] pc, input logic [31:0] ins);
    cycle(0, pc, ins, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst();
    cycle(1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: combinational outputs before the edge, IF/ID state after it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q[0];
        chk("pc_en", 32'(pc_en), 32'(e.en));
        chk("pc_next", pc_next, e.next);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("instr_d", instr_d, e.instr);
        chk("pc_d", pc_d, e.pc);
        chk("pc8_d", pc8_d, e.pc8);
        chk("valid_d", 32'(valid_d), 32'(e.valid));
        chk("fetch_err", 32'(fetch_err), 32'(e.err));
        chk("fetch_cnt", fetch_cnt, e.cnt);
      end
    end
  end

  initial begin
    logic [31:0] tpc, tgt, pcx;
    logic r, st, br, j, jrr;
    int halt_cycles;

    rst();
    for (int k = 0; k < 4; k++) run(32'h3000 + 32'(4 * k), 32'h11111111 * 32'(k + 1));
    for (int k = 0; k < 3; k++) cycle(0, 32'h3010, 32'h55555555, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 32'h3002, 32'h66666666, 1, 0, 0, 0, 0, 0, 0);
    run(32'h3010, 32'h55555555);

    // Jump with pc_d=0x3008, delay slot at 0x300C kept
    rst();
    run(32'h3000, 32'hA0); run(32'h3004, 32'hA1); run(32'h3008, 32'hA2);
    cycle(0, 32'h300C, 32'hA3, 0, 0, 0, 1, 26'h0000C40, 0, 0);
    run(32'h3100, 32'hB0);

    // jr beats branch; stall suppresses the redirect
    cycle(0, 32'h3104, 32'hB1, 0, 1, 32'h3400, 0, 0, 1, 32'h3200);
    cycle(0, 32'h3200, 32'hC0, 1, 1, 32'h3400, 0, 0, 1, 32'h3300);

    // Misaligned fault, hold in HALT, reset out of HALT
    run(32'h3002, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) cycle(0, 32'h3000 + 32'(4 * k), $urandom, 0, 1, 32'h3400, 0, 0, 1, 32'h3500);
    rst();
    run(32'h3000, 32'hE0); run(32'h3004, 32'hE1);

    // Range boundaries and reset under stall
    run(32'h3FFC, 32'hF0);
    run(32'h4000, 32'hF1);
    rst();
    run(32'h2FFC, 32'hF2);
    rst();
    run(32'hFFFFFFFC, 32'hF3);
    cycle(1, 32'h3000, 0, 1, 0, 0, 0, 0, 0, 0);
    run(32'h3000, 32'hF4);

    // Random phase: bench acts as the PC register fed from the model
    tpc = 32'h3004;
    halt_cycles = 0;
    for (int n = 0; n < 500; n++) begin
      r   = ($urandom_range(0, 99) == 0) || (halt_cycles > 6);
      st  = ($urandom_range(0, 3) == 0);
      jrr = ($urandom_range(0, 9) == 0);
      j   = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 6) == 0);
      tgt = 32'h3000 + 32'(4 * $urandom_range(0, 1023));
      if ($urandom_range(0, 49) == 0) tgt = $urandom;
      pcx = tpc;
      if ($urandom_range(0, 99) == 0) pcx = tpc | 32'h1;
      cycle(r, pcx, $urandom, st, br, tgt + 32'h40, j, tgt[27:2], jrr, tgt);
      halt_cycles = m_halt ? halt_cycles + 1 : 0;
      if (r) tpc = 32'h3000;
      else if (last_en) tpc = last_next;
    end

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-side controller for the pipelined MIPS core. It consumes the current fetch address from the PC register and the word read from instruction memory. It computes the next PC and the PC write-enable that feed back into the PC register. It also owns the IF/ID pipeline register, with stall hold, a fetch-fault state machine and a fetch counter. Branches use MIPS delay-slot semantics: the instruction after a branch/jump is always fetched and never flushed.

## Interface
Parameters:
- RESET_PC, 32'h00003000, PC value after reset; used for IF/ID reset contents.
- IM_BASE, 32'h00003000, lowest legal fetch address.
- IM_WORDS, 1024, number of instruction-memory words; legal range is [IM_BASE, IM_BASE+4*IM_WORDS).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pc_f  in  32  current fetch address (PC register output).
- instr_f  in  32  instruction word at pc_f (combinational IM read).
- stall  in  1  hazard-unit stall; freezes PC and IF/ID.
- id_branch  in  1  conditional branch in ID resolved taken.
- id_branch_target  in  32  branch target computed in ID.
- id_jump  in  1  j/jal in ID.
- id_jump_index  in  26  instr_index field of the j/jal in ID.
- id_jr  in  1  jr/jalr in ID.
- id_jr_target  in  32  forwarded rs value for jr/jalr.
- pc_next  out  32  next fetch address, to the PC register data input.
- pc_en  out  1  PC register write-enable.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc8_d  out  32  IF/ID PC+8 (link value).
- valid_d  out  1  IF/ID holds a real fetched instruction.
- fetch_err  out  1  sticky fetch fault; the core is halted.
- fetch_cnt  out  32  number of instructions accepted into IF/ID since reset.

## Operation
- State machine: RUN, HALT. Reset enters RUN. RUN→HALT on a fetch fault accepted in a non-stalled cycle. HALT is left only by reset.
- Fetch fault: pc_f[1:0]≠0, or pc_f<IM_BASE, or pc_f≥IM_BASE+4*IM_WORDS. The unsigned compare is done in 33 bits so no wrap occurs.
- pc_en (combinational): 1 iff state=RUN, stall=0 and no fault on pc_f. pc_en is 0 during the reset cycle.
- pc_next (combinational) uses priority id_jr > id_jump > id_branch > sequential:
  - jr: id_jr_target.
  - jump: {pc_d[31:28]+carry of pc_d+4, id_jump_index, 2'b00}, i.e. the top 4 bits of (pc_d+4).
  - branch: id_branch_target.
  - else: pc_f+4, mod 2^32.
- Redirect inputs are ignored whenever pc_en=0. The hazard unit re-presents them once the stall is released.
- IF/ID update, first matching rule wins:
  - reset → instr_d=0, pc_d=RESET_PC, pc8_d=RESET_PC+8, valid_d=0, fetch_cnt=0, fetch_err=0, state RUN.
  - HALT → hold all.
  - stall=1 → hold all, including the fault check (a faulting pc_f under stall does not halt).
  - fault → instr_d=0 (nop), pc_d=pc_f, pc8_d=pc_f+8, valid_d=0, fetch_err=1, state HALT, fetch_cnt unchanged.
  - else → instr_d=instr_f, pc_d=pc_f, pc8_d=pc_f+8, valid_d=1, fetch_cnt+1 (wraps at 2^32).
- No flush on a taken branch: the delay-slot instruction is already in IF when the branch is in ID, and it is kept.

## Timing
- IF/ID latency is 1 cycle: the pc_f/instr_f seen at edge N appears on pc_d/instr_d after edge N.
- A redirect issued while the branch is in ID (cycle N, pc_en=1) is in the PC after edge N. The target instruction reaches IF/ID after edge N+1, directly behind the delay slot.
- Stall held for k cycles freezes pc_f, IF/ID and fetch_cnt for exactly k edges.
- Reset asserted mid-HALT or mid-stall: on the next edge all outputs take their reset values and state returns to RUN.

## Test plan
- Reset, then run 4 cycles from pc_f=0x3000..0x300C with instr_f=0x11111111..0x44444444. Required: pc_en=1, pc_next=pc_f+4 each cycle; after the 4th edge instr_d=0x44444444, pc_d=0x300C, pc8_d=0x3014, fetch_cnt=4.
- Stall for 3 cycles at pc_f=0x3010. Required: pc_en=0 for those cycles; IF/ID and fetch_cnt unchanged; normal advance resumes the cycle after stall drops.
- pc_d=0x3008, id_jump=1, index=0x0000C40 (+4 upper bits 0). Required: pc_next=0x00003100; the delay slot at 0x300C is kept with valid_d=1.
- id_jr=1 (target 0x3200), id_branch=1 (target 0x3400) and stall=0 in the same cycle. Required: pc_next=0x3200. Repeat with stall=1. Required: pc_en=0 and no redirect.
- pc_f=0x3002 with no stall. Required: after the edge fetch_err=1, valid_d=0, instr_d=0, pc_d=0x3002; pc_en stays 0 and all outputs hold over 5 further cycles.
- Assert reset while in HALT. Required: after 1 edge fetch_err=0, valid_d=0, pc_d=0x3000, pc8_d=0x3008, fetch_cnt=0; fetching restarts at 0x3000.
